// File: rtl/core_pkg.sv
// Shared types and encodings for the iterative branch comparator.
// Holds the branch funct3 encodings, the FSM state type and the result decode.
package core_pkg;

    typedef logic [2:0] op_t;

    localparam op_t CMP_EQ  = 3'd0;
    localparam op_t CMP_NE  = 3'd1;
    localparam op_t CMP_LT  = 3'd4;
    localparam op_t CMP_GE  = 3'd5;
    localparam op_t CMP_LTU = 3'd6;
    localparam op_t CMP_GEU = 3'd7;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    function automatic logic is_signed_op(op_t op);
        return (op == CMP_LT) || (op == CMP_GE);
    endfunction

    // Reserved encodings (2, 3) always resolve to 0.
    function automatic logic cmp_result(op_t op, logic eq, logic lt);
        logic res;
        case (op)
            CMP_EQ:           res = eq;
            CMP_NE:           res = ~eq;
            CMP_LT, CMP_LTU:  res = lt;
            CMP_GE, CMP_GEU:  res = ~lt;
            default:          res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned comparison of one CHUNK-bit slice.
module cmp_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/branch_compare_iter.sv
// Multi-cycle branch comparator: scans operands MSB chunk first, CHUNK bits per cycle,
// optionally stopping at the first differing chunk. Valid/ready on both sides.
module branch_compare_iter
    import core_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned CHUNK      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out,
    output logic            busy
);

    localparam int unsigned NCHUNK = XLEN / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((XLEN % CHUNK) != 0) begin : g_bad_cfg
        $error("branch_compare_iter: XLEN must be a multiple of CHUNK");
    end

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    op_t               op_q, op_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic              out_q, out_d;

    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic              c_eq, c_lt, first_diff;

    assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

    cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_cmp_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .eq (c_eq),
        .lt (c_lt)
    );

    // Only the most significant differing chunk decides the ordering.
    assign first_diff = eq_q & ~c_eq;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SCAN: begin
                if (first_diff) begin
                    eq_d = 1'b0;
                    lt_d = c_lt;
                end
                if ((EARLY_EXIT && first_diff) || (idx_q == '0)) begin
                    state_d = DONE;
                    out_d   = cmp_result(op_q, eq_d, lt_d);
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (in_valid && in_ready) begin
            state_d = SCAN;
            idx_d   = IDXW'(NCHUNK - 1);
            a_d     = in1;
            b_d     = in2;
            op_d    = op;
            eq_d    = 1'b1;
            lt_d    = 1'b0;
            // Flipping the sign bits maps signed order onto unsigned order.
            if (is_signed_op(op)) begin
                a_d[XLEN-1] = ~in1[XLEN-1];
                b_d[XLEN-1] = ~in2[XLEN-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= CMP_EQ;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            out_q   <= out_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_branch_compare_iter.sv
// Bench for branch_compare_iter: three configurations (8-bit chunks with and without early
// exit, single 32-bit chunk), table-driven vectors plus stall/back-to-back/reset sequences.
module tb_branch_compare_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid_v  [3];
    logic        in_ready_v  [3];
    logic [31:0] in1_v       [3];
    logic [31:0] in2_v       [3];
    logic [2:0]  op_v        [3];
    logic        out_valid_v [3];
    logic        out_ready_v [3];
    logic        out_v       [3];
    logic        busy_v      [3];

    int total;
    int passed;

    typedef struct {
        logic exp;
        int   lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        exp;
        int          lat;
    } vec_t;

    branch_compare_iter #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in1(in1_v[0]), .in2(in2_v[0]), .op(op_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .out(out_v[0]), .busy(busy_v[0])
    );

    branch_compare_iter #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in1(in1_v[1]), .in2(in2_v[1]), .op(op_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .out(out_v[1]), .busy(busy_v[1])
    );

    branch_compare_iter #(.XLEN(32), .CHUNK(32), .EARLY_EXIT(1'b1)) u_dut_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in1(in1_v[2]), .in2(in2_v[2]), .op(op_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .out(out_v[2]), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drives a request from a negedge, returns at the negedge after the accept edge.
    task automatic start(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic exp, input int lat);
        int n;
        @(negedge clk);
        in1_v[d]      = a;
        in2_v[d]      = b;
        op_v[d]       = op;
        in_valid_v[d] = 1'b1;
        n = 0;
        while (!in_ready_v[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        sb.push_back('{exp: exp, lat: lat});
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        in1_v[d]      = ~a;
        in2_v[d]      = ~b;
    endtask

    // Waits for out_valid; leaves the result pending in DONE.
    task automatic finish(input int d, input string name);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid_v[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (n >= 40) check({name, "_timeout"}, 32'(n), 32'd0);
        else begin
            check({name, "_out"}, 32'(out_v[d]), 32'(e.exp));
            check({name, "_lat"}, 32'(n), 32'(e.lat));
        end
    endtask

    task automatic release_out(input int d);
        out_ready_v[d] = 1'b1;
        @(negedge clk);
        out_ready_v[d] = 1'b0;
        check("release_out_valid", 32'(out_valid_v[d]), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i]  = 1'b0;
            out_ready_v[i] = 1'b0;
            in1_v[i]       = '0;
            in2_v[i]       = '0;
            op_v[i]        = '0;
        end

        vecs.push_back('{0, 32'h12345678, 32'h12345678, 3'd0, 1'b1, 4});
        vecs.push_back('{0, 32'h12345678, 32'h12345678, 3'd1, 1'b0, 4});
        vecs.push_back('{0, 32'h80000000, 32'h00000001, 3'd4, 1'b1, 1});
        vecs.push_back('{0, 32'h80000000, 32'h00000001, 3'd6, 1'b0, 1});
        vecs.push_back('{0, 32'h80000000, 32'h00000001, 3'd7, 1'b1, 1});
        vecs.push_back('{0, 32'h80000000, 32'h00000001, 3'd5, 1'b0, 1});
        vecs.push_back('{0, 32'h12345600, 32'h12345601, 3'd6, 1'b1, 4});
        vecs.push_back('{0, 32'h12345600, 32'h12345601, 3'd0, 1'b0, 4});
        vecs.push_back('{0, 32'hFFFFFFFE, 32'hFFFFFFFF, 3'd4, 1'b1, 4});
        vecs.push_back('{0, 32'h00000001, 32'h80000000, 3'd5, 1'b1, 1});
        vecs.push_back('{0, 32'h12345678, 32'h12345678, 3'd2, 1'b0, 4});
        vecs.push_back('{0, 32'hFF000000, 32'h00000000, 3'd3, 1'b0, 1});
        vecs.push_back('{1, 32'h02000000, 32'h01000005, 3'd6, 1'b0, 4});
        vecs.push_back('{1, 32'h02000000, 32'h01000005, 3'd1, 1'b1, 4});
        vecs.push_back('{1, 32'h00000010, 32'h00000020, 3'd4, 1'b1, 4});
        vecs.push_back('{2, 32'hFFFFFFFF, 32'h00000000, 3'd5, 1'b0, 1});
        vecs.push_back('{2, 32'h00000005, 32'h00000007, 3'd4, 1'b1, 1});
        vecs.push_back('{2, 32'h00000009, 32'h00000009, 3'd0, 1'b1, 1});

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_out_valid", 32'(out_valid_v[i]), 32'd0);
            check("rst_busy", 32'(busy_v[i]), 32'd0);
            check("rst_out", 32'(out_v[i]), 32'd0);
            check("rst_in_ready", 32'(in_ready_v[i]), 32'd1);
        end
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].lat);
            finish(vecs[i].d, $sformatf("vec%0d", i));
            release_out(vecs[i].d);
        end

        // Stall in DONE, then release together with a new request.
        start(0, 32'h80000000, 32'h00000001, 3'd4, 1'b1, 1);
        finish(0, "stall_first");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid_v[0]), 32'd1);
            check("stall_out", 32'(out_v[0]), 32'd1);
            check("stall_in_ready", 32'(in_ready_v[0]), 32'd0);
        end
        in1_v[0]       = 32'h12345678;
        in2_v[0]       = 32'h12345678;
        op_v[0]        = 3'd0;
        in_valid_v[0]  = 1'b1;
        out_ready_v[0] = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready_v[0]), 32'd1);
        @(posedge clk);
        sb.push_back('{exp: 1'b1, lat: 4});
        @(negedge clk);
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b0;
        check("b2b_busy", 32'(busy_v[0]), 32'd1);
        check("b2b_out_valid", 32'(out_valid_v[0]), 32'd0);
        finish(0, "b2b_second");
        release_out(0);

        // Asynchronous reset mid-SCAN.
        start(0, 32'h12345678, 32'h12345678, 3'd0, 1'b1, 4);
        check("pre_rst_busy", 32'(busy_v[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("scan_rst_busy", 32'(busy_v[0]), 32'd0);
        check("scan_rst_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("scan_rst_in_ready", 32'(in_ready_v[0]), 32'd1);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-DONE drops the pending result.
        start(0, 32'hFF000000, 32'h00000000, 3'd6, 1'b0, 1);
        finish(0, "done_pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check("done_rst_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("done_rst_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start(0, 32'h00000000, 32'h00000001, 3'd7, 1'b0, 4);
        finish(0, "post_rst");
        release_out(0);
        start(0, 32'h00001234, 32'h00005678, 3'd2, 1'b0, 3);
        finish(0, "post_rst_reserved");
        release_out(0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
